step_ctrl: RTL and testbench
============================

Name: step_ctrl

Overview:
Generates the CPU step strobe and the executed-step count from the two raw board push-buttons. It sits directly upstream of the single-cycle CPU core and drives that core's step clock input.
Button 0 is single-step and button 1 toggles free-run mode; free-run mode steps at a programmable rate.
The block replaces the bare debouncer plus external step counter.

Parameters:
DB_CYCLES, 50000, consecutive stable clk cycles before a debounced level changes (bench uses 4)
DIV_W, 24, width of run-rate divider
CNT_W, 16, width of step counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn  input  2  raw push-buttons; [0]=step, [1]=run/stop toggle; asynchronous to clk
halt  input  1  CPU halted; forces exit from RUN and blocks RUN entry
run_div  input  DIV_W  free-run period minus 1, in clk cycles
step_pulse  output  1  registered one-clk-wide step strobe to CPU
running  output  1  high while in RUN state
btn_level  output  2  debounced button levels
step_cnt  output  CNT_W  number of step_pulse strobes since reset

Behaviour:
- Reset (rst=0, async): state IDLE; step_pulse=0, running=0, btn_level=0, step_cnt=0. Synchronizers, debounce counters and divider are all cleared.
- Per button:
  - Two-flop synchronizer.
  - Counter increments while the synced value differs from btn_level and clears when they are equal.
  - When the counter reaches DB_CYCLES-1, btn_level flips and the counter clears. Any bounce restarts the count.
  - A rise pulse (one cycle) is generated when btn_level goes 0->1. Releasing a button produces no event.
- Internal events: step_req = rise[0]; mode_req = rise[1].
- FSM states are IDLE, STEP and RUN. All outputs are flops.
  - IDLE:
    - If mode_req and !halt: go to RUN, load div_cnt<=run_div, running<=1. mode_req has priority over a simultaneous step_req; the step_req is dropped.
    - Else if step_req: go to STEP, step_pulse<=1. This applies even when halt=1.
    - A mode_req with halt=1 is ignored.
  - STEP: step_pulse<=0, then return to IDLE. step_pulse is high exactly one cycle, the cycle after rise[0].
  - RUN:
    - Exit condition: if halt or mode_req, go to IDLE with running<=0 and step_pulse<=0. No pulse is issued in the exit cycle.
    - Otherwise, if div_cnt==0: step_pulse<=1 and div_cnt<=run_div. run_div is resampled at each reload.
    - Otherwise: step_pulse<=0 and div_cnt<=div_cnt-1.
    - step_req is ignored in RUN.
    - Timing: the first pulse is run_div+1 cycles after RUN entry, and the period is run_div+1 cycles. run_div=0 gives a pulse every cycle.
- step_cnt increments by 1 in the cycle after each step_pulse=1. It wraps from all-ones to 0.
- Latency from a raw button held stable to step_pulse: 2 (sync) + DB_CYCLES + 1 (rise/FSM) cycles, fixed.
- A reset asserted mid-RUN or mid-STEP drops step_pulse immediately (async). No partial pulse is emitted after reset release.

Decomposition:
- Shared package: state encoding S_IDLE=2'd0, S_STEP=2'd1, S_RUN=2'd2; button index constants BTN_STEP=0, BTN_MODE=1.
- One sub-module, btn_debounce: one button's synchronizer, debounce counter, level and rise pulse, parameterised by DB_CYCLES. It is instantiated twice.
- FSM, divider and step counter live in step_ctrl.

Test Plan:
- Reset: hold rst=0 with btn=2'b11 -> step_pulse=0, running=0, btn_level=0, step_cnt=0 throughout. Release rst with btn held -> btn_level=2'b11 after 2+4 cycles and RUN is entered.
- Bounce (DB_CYCLES=4): btn[0] toggles every 2 cycles for 20 cycles, then held 1 -> no pulse during bounce. Exactly one step_pulse occurs 7 cycles after the last edge; step_cnt=1. Release gives no pulse.
- Free run: run_div=3, press btn[1] -> running=1; step_pulse high every 4th cycle starting 4 cycles after entry; after 40 cycles step_cnt=10. Second btn[1] press -> running=0 and pulses stop.
- Halt: in RUN with run_div=0, assert halt -> running=0 next cycle with no pulse in that cycle. btn[1] with halt=1 -> stays IDLE. btn[0] with halt=1 -> one pulse.
- Simultaneous: btn[0] and btn[1] rise in the same cycle -> RUN entered, no STEP pulse, step_cnt unchanged until the first run pulse.
- Wrap and reset: preload to step_cnt=16'hFFFF via run, then one step -> step_cnt=0. Assert rst mid-RUN while step_pulse=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
// Shared definitions for the step controller: FSM state encoding and the
// button index assignments used by step_ctrl and btn_debounce.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One push-button conditioner: two-flop synchronizer, stability counter,
// debounced level and a one-cycle rise pulse on a 0->1 level change.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_raw  raw button input, asynchronous to clk
//   level    debounced button level
//   rise     one-cycle pulse, registered together with level going 0->1
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level, so any bounce back to the current level restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      rise <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          rise  <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl
// Turns the two board push-buttons into the CPU step strobe. Button 0 issues
// a single step, button 1 toggles free-run mode, which steps every
// run_div+1 cycles. Also counts issued steps.
//
// state  | meaning
// IDLE   | waiting for a step or run request
// STEP   | single step strobe is high this cycle
// RUN    | free-running, strobing every run_div+1 cycles
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   btn[1:0]    raw buttons, [0]=step, [1]=run/stop toggle
//   halt        CPU halted; leaves RUN and prevents entering it
//   run_div     free-run period minus one, in clk cycles
//   step_pulse  one-cycle step strobe to the CPU
//   running     high while in RUN
//   btn_level   debounced button levels
//   step_cnt    number of step strobes since reset (wraps)
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 50000,
  parameter int DIV_W     = 24,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       btn,
  input  logic             halt,
  input  logic [DIV_W-1:0] run_div,
  output logic             step_pulse,
  output logic             running,
  output logic [1:0]       btn_level,
  output logic [CNT_W-1:0] step_cnt
);

  logic [1:0]       rise;
  logic             step_req;
  logic             mode_req;
  state_t           state;
  logic [DIV_W-1:0] div_cnt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn[BTN_STEP]),
    .level   (btn_level[BTN_STEP]),
    .rise    (rise[BTN_STEP])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn[BTN_MODE]),
    .level   (btn_level[BTN_MODE]),
    .rise    (rise[BTN_MODE])
  );

  assign step_req = rise[BTN_STEP];
  assign mode_req = rise[BTN_MODE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      step_pulse <= 1'b0;
      running    <= 1'b0;
      div_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          step_pulse <= 1'b0;
          // A run request wins over a coincident step request.
          if (mode_req && !halt) begin
            state   <= S_RUN;
            running <= 1'b1;
            div_cnt <= run_div;
          end else if (step_req) begin
            state      <= S_STEP;
            step_pulse <= 1'b1;
          end
        end
        S_STEP: begin
          step_pulse <= 1'b0;
          state      <= S_IDLE;
        end
        S_RUN: begin
          if (halt || mode_req) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            step_pulse <= 1'b0;
          end else if (div_cnt == '0) begin
            step_pulse <= 1'b1;
            div_cnt    <= run_div;
          end else begin
            step_pulse <= 1'b0;
            div_cnt    <= div_cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          step_pulse <= 1'b0;
          running    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
    end else if (step_pulse) begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
module tb_step_ctrl;

  localparam int DB    = 4;
  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       btn = 2'b11;
  logic             halt = 1'b0;
  logic [DIV_W-1:0] run_div = 8'd3;
  logic             step_pulse;
  logic             running;
  logic [1:0]       btn_level;
  logic [CNT_W-1:0] step_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  step_ctrl #(.DB_CYCLES(DB), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .halt       (halt),
    .run_div    (run_div),
    .step_pulse (step_pulse),
    .running    (running),
    .btn_level  (btn_level),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: the level flips on the DB-th consecutive clock where the
  // two-cycle-delayed input disagrees with it. Free run: pulses are scheduled
  // as absolute cycle numbers, run_div+1 after entry or after the last pulse.
  logic [19:0] exp_q[$];
  logic [1:0]  ms1, ms2, mlvl, mrise_prev, rise_new;
  int          mrun[2];
  int          m_mode;      // 0 idle, 1 single step, 2 run
  longint      cyc_n, next_pulse;
  logic        m_pulse, pulse_old;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    if (!rst) begin
      ms1 = '0; ms2 = '0; mlvl = '0; mrise_prev = '0;
      mrun[0] = 0; mrun[1] = 0;
      m_mode = 0; m_pulse = 1'b0; m_cnt = '0;
      cyc_n = 0; next_pulse = 0;
    end else begin
      rise_new = '0;
      for (int b = 0; b < 2; b++) begin
        if (ms2[b] != mlvl[b]) begin
          mrun[b] = mrun[b] + 1;
          if (mrun[b] == DB) begin
            mlvl[b]     = ~mlvl[b];
            rise_new[b] = mlvl[b];
            mrun[b]     = 0;
          end
        end else begin
          mrun[b] = 0;
        end
      end
      ms2 = ms1;
      ms1 = btn;
      pulse_old = m_pulse;
      if (m_mode == 0) begin
        if (mrise_prev[1] && !halt) begin
          m_mode = 2; m_pulse = 1'b0;
          next_pulse = cyc_n + longint'(run_div) + 1;
        end else if (mrise_prev[0]) begin
          m_mode = 1; m_pulse = 1'b1;
        end else begin
          m_pulse = 1'b0;
        end
      end else if (m_mode == 1) begin
        m_mode = 0; m_pulse = 1'b0;
      end else begin
        if (halt || mrise_prev[1]) begin
          m_mode = 0; m_pulse = 1'b0;
        end else if (cyc_n == next_pulse) begin
          m_pulse = 1'b1;
          next_pulse = cyc_n + longint'(run_div) + 1;
        end else begin
          m_pulse = 1'b0;
        end
      end
      m_cnt = m_cnt + 16'(pulse_old);
      mrise_prev = rise_new;
      cyc_n++;
    end
    exp_q.push_back({m_pulse, (m_mode == 2), mlvl, m_cnt});
  end

  // ---------------- monitor ----------------
  logic [19:0] exp_v, got_v;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {step_pulse, running, btn_level, step_cnt};
      check("pulse/running/level/cnt", {12'd0, got_v}, {12'd0, exp_v});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] m, input int hold);
    @(negedge clk);
    btn = btn | m;
    cyc(hold);
    btn = btn & ~m;
    cyc(hold);
  endtask

  initial begin
    #1 rst = 1'b0;
    // Reset held with both buttons down.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {12'd0, step_pulse, running, btn_level, step_cnt}, 32'd0);
    end
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #2 check("level_after_release", {30'd0, btn_level}, 32'd3);
    @(posedge clk);
    #2 check("run_after_release", {31'd0, running}, 32'd1);

    // Release buttons (no events), free-run at run_div=3, then stop.
    @(negedge clk);
    btn = 2'b00;
    cyc(50);
    press(2'b10, 10);
    check("stopped", {31'd0, running}, 32'd0);
    cyc(10);

    // Bounce on step button, then a clean hold and release.
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      cyc(2);
    end
    btn[0] = 1'b1;
    cyc(12);
    btn[0] = 1'b0;
    cyc(12);

    // Simultaneous press: RUN wins, no single step.
    press(2'b11, 10);
    cyc(20);
    press(2'b10, 10);

    // Halt behaviour.
    run_div = 8'd0;
    press(2'b10, 10);
    cyc(5);
    halt = 1'b1;
    cyc(3);
    check("halt_exit", {31'd0, running}, 32'd0);
    press(2'b10, 10);
    press(2'b01, 10);
    halt = 1'b0;
    cyc(5);

    // Randomised phase.
    for (int i = 0; i < 150; i++) begin
      btn     = 2'($urandom_range(0, 3));
      halt    = ($urandom_range(0, 7) == 0);
      run_div = 8'($urandom_range(0, 5));
      cyc($urandom_range(1, 12));
    end
    btn = 2'b00;
    halt = 1'b1;
    cyc(12);
    halt = 1'b0;

    // Run up to near wrap, then finish the count with single steps under halt.
    run_div = 8'd0;
    press(2'b10, 10);
    for (int i = 0; i < 70000 && m_cnt < 16'hFFF0; i++) @(negedge clk);
    check("wrap_reach_bound", {31'd0, (m_cnt >= 16'hFFF0)}, 32'd1);
    halt = 1'b1;
    cyc(4);
    for (int i = 0; i < 40 && m_cnt != 16'hFFFF; i++) press(2'b01, 10);
    check("before_wrap", {16'd0, step_cnt}, 32'h0000FFFF);
    press(2'b01, 10);
    check("wrap_to_zero", {16'd0, step_cnt}, 32'd0);
    halt = 1'b0;

    // Async reset while a run pulse is high.
    @(negedge clk);
    btn = 2'b10;
    cyc(10);
    for (int i = 0; i < 20 && !m_pulse; i++) begin
      @(posedge clk);
      #3;
    end
    check("pulse_before_reset", {31'd0, step_pulse}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_pulse", {31'd0, step_pulse}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_level", {30'd0, btn_level}, 32'd0);
    check("rst_cnt", {16'd0, step_cnt}, 32'd0);
    @(negedge clk);
    btn = 2'b00;
    cyc(2);
    rst = 1'b1;
    cyc(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
